// File: rtl/dmem_stbuf.sv
// Data memory (64 x 32) with an optional 4-entry store buffer and load forwarding.
// Define DMEM_STBUF_FWD_EN to include the store buffer; otherwise stores write straight through.
module dmem_stbuf (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [2:0]  sb_count,
  output logic        sb_full
);

  logic [31:0] r_mem [64];
  logic [5:0]  w_idx;
  logic        w_unused;

  assign w_idx    = addr[7:2];
  assign w_unused = &{1'b0, addr[31:8], addr[1:0]};

`ifdef DMEM_STBUF_FWD_EN

  logic [5:0]  r_sb_idx  [4];
  logic [31:0] r_sb_data [4];
  logic [3:0]  r_sb_valid;
  logic [1:0]  r_head;
  logic [1:0]  r_tail;
  logic [2:0]  r_count;
  logic        w_full;
  logic        w_drain;
  logic        w_enq;
  logic [1:0]  w_slot;
  logic [31:0] w_rdata;

  assign w_full  = (r_count == 3'd4);
  assign w_enq   = memwrite;
  // A store never stalls: when full, the head drains in the same edge the new store lands.
  assign w_drain = memwrite ? w_full : (r_count != 3'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_count    <= 3'd0;
      r_sb_valid <= 4'b0000;
    end else begin
      if (w_drain) begin
        r_sb_valid[r_head] <= 1'b0;
        r_head             <= r_head + 2'd1;
      end
      if (w_enq) begin
        r_sb_valid[r_tail] <= 1'b1;
        r_tail             <= r_tail + 2'd1;
      end
      if (w_enq && !w_drain)
        r_count <= r_count + 3'd1;
      else if (!w_enq && w_drain)
        r_count <= r_count - 3'd1;
    end
  end

  // NOTE: payload storage is deliberately not reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_sb_idx[r_tail]  <= w_idx;
      r_sb_data[r_tail] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_drain)
      r_mem[r_sb_idx[r_head]] <= r_sb_data[r_head];
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rdata = r_mem[w_idx];
    w_slot  = r_head;
    for (int k = 0; k < 4; k++) begin
      w_slot = r_head + 2'(k);
      if (r_sb_valid[w_slot] && (r_sb_idx[w_slot] == w_idx))
        w_rdata = r_sb_data[w_slot];
    end
  end

  assign readdata = w_rdata;
  assign sb_count = r_count;
  assign sb_full  = w_full;

`else

  always_ff @(posedge clk) begin
    if (!reset && memwrite)
      r_mem[w_idx] <= writedata;
  end

  assign readdata = r_mem[w_idx];
  assign sb_count = 3'd0;
  assign sb_full  = 1'b0;

`endif

endmodule
